// File: rtl/udp_vlg_pkg.sv
// Shared types for the UDP receive path: port-binding entries and sizing helpers.
package udp_vlg_pkg;

  localparam int UDP_DISP_MAX_N = 16;

  typedef struct packed {
    logic        en;
    logic [15:0] port;
  } udp_bind_t;

  // Index width that stays legal for a single-entry table.
  function automatic int udp_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/udp_vlg_port_match.sv
// Combinational priority matcher: reports the lowest enabled binding whose port equals i_port.
module udp_vlg_port_match
  import udp_vlg_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = udp_idx_w(N)
) (
  input  udp_bind_t       i_tbl [N],
  input  logic [15:0]     i_port,
  output logic            o_hit,
  output logic [IW-1:0]   o_idx
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_tbl[i].en && (i_tbl[i].port == i_port)) begin
        o_hit = 1'b1;
        o_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/udp_vlg_rx_dispatch.sv
// Routes each UDP RX datagram to the consumer channel bound to its dst_port; unmatched
// datagrams are dropped and counted. One register stage, no backpressure.
//
//  state   | meaning
//  IDLE    | waiting for a start-of-datagram byte
//  FWD     | forwarding the current datagram to channel r_sel
//  DROP    | discarding an unmatched datagram until its eof
module udp_vlg_rx_dispatch
  import udp_vlg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              in_dat,
  input  logic                    in_val,
  input  logic                    in_sof,
  input  logic                    in_eof,
  input  logic                    in_err,
  input  logic [15:0]             in_dst_port,
  input  logic                    cfg_wr,
  input  logic [udp_idx_w(N)-1:0] cfg_idx,
  input  logic [15:0]             cfg_port,
  input  logic                    cfg_en,
  output logic [7:0]              out_dat,
  output logic [N-1:0]            out_val,
  output logic [N-1:0]            out_sof,
  output logic [N-1:0]            out_eof,
  output logic [N-1:0]            out_err,
  output logic                    busy,
  output logic [15:0]             drop_cnt
);

  localparam int IW = udp_idx_w(N);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  udp_bind_t       r_tbl [N];
  logic [1:0]      r_state;
  logic [IW-1:0]   r_sel;
  logic            r_pend;
  logic [15:0]     r_drop_cnt;
  logic [7:0]      r_out_dat;
  logic [N-1:0]    r_out_val;
  logic [N-1:0]    r_out_sof;
  logic [N-1:0]    r_out_eof;
  logic [N-1:0]    r_out_err;

  logic            w_hit;
  logic [IW-1:0]   w_idx;
  logic            w_sof_take;
  logic [1:0]      w_state_nxt;
  logic [IW-1:0]   w_sel_nxt;
  logic            w_pend_nxt;
  logic            w_drop_inc;
  logic [N-1:0]    w_val_nxt;
  logic [N-1:0]    w_sof_nxt;
  logic [N-1:0]    w_eof_nxt;
  logic [N-1:0]    w_err_nxt;

  udp_vlg_port_match #(
    .N  (N),
    .IW (IW)
  ) u_match (
    .i_tbl  (r_tbl),
    .i_port (in_dst_port),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  assign w_sof_take = in_val && in_sof;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_pend_nxt  = r_pend;
    w_drop_inc  = 1'b0;
    w_val_nxt   = '0;
    w_sof_nxt   = '0;
    w_eof_nxt   = '0;
    w_err_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        w_pend_nxt = 1'b0;
        if (w_sof_take) begin
          if (w_hit) begin
            w_val_nxt[w_idx] = 1'b1;
            w_sof_nxt[w_idx] = 1'b1;
            w_eof_nxt[w_idx] = in_eof;
            w_sel_nxt        = w_idx;
            if (!in_eof) w_state_nxt = ST_FWD;
          end else begin
            w_drop_inc = 1'b1;
            if (!in_eof) w_state_nxt = ST_DROP;
          end
        end
      end
      ST_FWD: begin
        if (in_err) begin
          w_err_nxt[r_sel] = 1'b1;
          w_eof_nxt[r_sel] = 1'b1;
          w_pend_nxt       = 1'b0;
          w_state_nxt      = ST_IDLE;
        end else if (w_sof_take) begin
          // Missing eof: abort the old datagram and start the new one in the same cycle.
          w_err_nxt[r_sel] = 1'b1;
          w_pend_nxt       = 1'b0;
          if (!w_hit) begin
            w_drop_inc  = 1'b1;
            w_state_nxt = in_eof ? ST_IDLE : ST_DROP;
          end else if (w_idx != r_sel) begin
            w_val_nxt[w_idx] = 1'b1;
            w_sof_nxt[w_idx] = 1'b1;
            w_eof_nxt[w_idx] = in_eof;
            w_sel_nxt        = w_idx;
            w_state_nxt      = in_eof ? ST_IDLE : ST_FWD;
          end else begin
            // Same channel: err owns this cycle, sof moves to the next valid byte.
            w_pend_nxt  = !in_eof;
            w_state_nxt = in_eof ? ST_IDLE : ST_FWD;
          end
        end else if (in_val) begin
          w_val_nxt[r_sel] = 1'b1;
          w_sof_nxt[r_sel] = r_pend;
          w_eof_nxt[r_sel] = in_eof;
          w_pend_nxt       = 1'b0;
          if (in_eof) w_state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (in_err || (in_val && in_eof)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_tbl[i] <= '0;
    end else if (cfg_wr && (int'(cfg_idx) < N)) begin
      r_tbl[cfg_idx] <= '{en: cfg_en, port: cfg_port};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_pend     <= 1'b0;
      r_drop_cnt <= '0;
      r_out_dat  <= '0;
      r_out_val  <= '0;
      r_out_sof  <= '0;
      r_out_eof  <= '0;
      r_out_err  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_pend    <= w_pend_nxt;
      r_out_dat <= in_dat;
      r_out_val <= w_val_nxt;
      r_out_sof <= w_sof_nxt;
      r_out_eof <= w_eof_nxt;
      r_out_err <= w_err_nxt;
      if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign out_dat  = r_out_dat;
  assign out_val  = r_out_val;
  assign out_sof  = r_out_sof;
  assign out_eof  = r_out_eof;
  assign out_err  = r_out_err;
  assign busy     = (r_state != ST_IDLE);
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_udp_vlg_rx_dispatch.sv
// Scoreboard bench for udp_vlg_rx_dispatch: directed scenarios followed by random datagrams.
module tb_udp_vlg_rx_dispatch;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CTX_IDLE = -2;
  localparam int CTX_DROP = -1;

  typedef struct packed {
    logic [7:0]   dat;
    logic [N-1:0] val;
    logic [N-1:0] sof;
    logic [N-1:0] eof;
    logic [N-1:0] err;
    logic         busy;
    logic [15:0]  drop;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_dat;
  logic          in_val, in_sof, in_eof, in_err;
  logic [15:0]   in_dst_port;
  logic          cfg_wr;
  logic [IW-1:0] cfg_idx;
  logic [15:0]   cfg_port;
  logic          cfg_en;
  logic [7:0]    out_dat;
  logic [N-1:0]  out_val, out_sof, out_eof, out_err;
  logic          busy;
  logic [15:0]   drop_cnt;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];

  // Reference model: binding table plus where the current datagram is going.
  bit          m_en   [N];
  logic [15:0] m_port [N];
  int          m_ctx;
  bit          m_pend;
  int          m_drop;

  udp_vlg_rx_dispatch #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_dat(in_dat), .in_val(in_val), .in_sof(in_sof), .in_eof(in_eof),
    .in_err(in_err), .in_dst_port(in_dst_port),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_port(cfg_port), .cfg_en(cfg_en),
    .out_dat(out_dat), .out_val(out_val), .out_sof(out_sof), .out_eof(out_eof),
    .out_err(out_err), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i]   = 1'b0;
      m_port[i] = 16'd0;
    end
    m_ctx  = CTX_IDLE;
    m_pend = 1'b0;
    m_drop = 0;
  endtask

  function automatic int lookup(input logic [15:0] p);
    for (int i = 0; i < N; i++)
      if (m_en[i] && m_port[i] == p) return i;
    return -1;
  endfunction

  task automatic bump_drop();
    if (m_drop < 65535) m_drop++;
  endtask

  task automatic model_step(input logic [7:0] d, input bit v, input bit s, input bit e,
                            input bit er, input logic [15:0] p, input bit cw, input int ci,
                            input logic [15:0] cp, input bit ce, output exp_t x);
    int hit;
    int c;
    x     = '0;
    x.dat = d;
    hit   = lookup(p);
    if (m_ctx == CTX_IDLE) begin
      if (v && s) begin
        if (hit >= 0) begin
          x.val[hit] = 1'b1; x.sof[hit] = 1'b1; x.eof[hit] = e;
          if (!e) m_ctx = hit;
        end else begin
          bump_drop();
          if (!e) m_ctx = CTX_DROP;
        end
      end
    end else if (m_ctx == CTX_DROP) begin
      if (er || (v && e)) m_ctx = CTX_IDLE;
    end else begin
      c = m_ctx;
      if (er) begin
        x.err[c] = 1'b1; x.eof[c] = 1'b1;
        m_ctx = CTX_IDLE; m_pend = 1'b0;
      end else if (v && s) begin
        x.err[c] = 1'b1;
        m_pend   = 1'b0;
        if (hit < 0) begin
          bump_drop();
          m_ctx = e ? CTX_IDLE : CTX_DROP;
        end else if (hit != c) begin
          x.val[hit] = 1'b1; x.sof[hit] = 1'b1; x.eof[hit] = e;
          m_ctx = e ? CTX_IDLE : hit;
        end else begin
          m_ctx  = e ? CTX_IDLE : c;
          m_pend = !e;
        end
      end else if (v) begin
        x.val[c] = 1'b1; x.sof[c] = m_pend; x.eof[c] = e;
        m_pend = 1'b0;
        if (e) m_ctx = CTX_IDLE;
      end
    end
    if (cw && ci < N) begin
      m_en[ci]   = ce;
      m_port[ci] = cp;
    end
    x.busy = (m_ctx != CTX_IDLE);
    x.drop = 16'(m_drop);
  endtask

  // One clock of stimulus: drive after the falling edge, expectation queued for the next rise.
  task automatic cyc(input logic [7:0] d, input bit v, input bit s, input bit e, input bit er,
                     input logic [15:0] p, input bit cw, input int ci, input logic [15:0] cp,
                     input bit ce);
    exp_t x;
    in_dat = d; in_val = v; in_sof = s; in_eof = e; in_err = er; in_dst_port = p;
    cfg_wr = cw; cfg_idx = IW'(ci); cfg_port = cp; cfg_en = ce;
    model_step(d, v, s, e, er, p, cw, ci, cp, ce, x);
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rand_err);
    for (int i = 0; i < n; i++)
      cyc(8'($urandom), 1'b0, 1'b0, 1'b0, rand_err && ($urandom_range(0, 3) == 0),
          16'($urandom), 1'b0, 0, 16'd0, 1'b0);
  endtask

  task automatic cfg(input int ci, input logic [15:0] cp, input bit ce);
    cyc(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, ci, cp, ce);
  endtask

  task automatic send(input logic [15:0] p, input int len, input int err_at, input bit no_eof,
                      input int cfg_at, input int ci, input logic [15:0] cp, input bit ce,
                      input bit gaps);
    for (int b = 0; b < len; b++) begin
      if (gaps && b > 0 && $urandom_range(0, 2) == 0)
        cyc(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, p, 1'b0, 0, 16'd0, 1'b0);
      cyc(8'($urandom), 1'b1, b == 0, (b == len - 1) && !no_eof, b == err_at, p,
          b == cfg_at, ci, cp, ce);
      if (b == err_at) break;
    end
  endtask

  task automatic dg(input logic [15:0] p, input int len);
    send(p, len, -1, 1'b0, -1, 0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {out_dat, out_val, out_sof, out_eof, out_err, busy, drop_cnt}, 64'd0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rst_n && q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("out_dat",  64'(out_dat),  64'(x.dat));
      chk("out_val",  64'(out_val),  64'(x.val));
      chk("out_sof",  64'(out_sof),  64'(x.sof));
      chk("out_eof",  64'(out_eof),  64'(x.eof));
      chk("out_err",  64'(out_err),  64'(x.err));
      chk("busy",     64'(busy),     64'(x.busy));
      chk("drop_cnt", 64'(drop_cnt), 64'(x.drop));
    end
  end

  initial begin
    rst_n = 1'b0;
    in_dat = '0; in_val = 0; in_sof = 0; in_eof = 0; in_err = 0; in_dst_port = '0;
    cfg_wr = 0; cfg_idx = '0; cfg_port = '0; cfg_en = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;

    // Basic forwarding and drop.
    cfg(0, 16'd5000, 1'b1);
    cfg(2, 16'd7000, 1'b1);
    dg(16'd7000, 10);
    idle(2, 1'b0);
    dg(16'd6000, 4);
    idle(1, 1'b1);

    // Upstream error on byte 4, then a clean datagram.
    send(16'd5000, 8, 3, 1'b0, -1, 0, 16'd0, 1'b0, 1'b0);
    idle(2, 1'b0);
    dg(16'd5000, 5);

    // Rebinding mid-datagram leaves the in-flight one alone.
    send(16'd7000, 8, -1, 1'b0, 3, 2, 16'd8000, 1'b1, 1'b0);
    dg(16'd7000, 3);
    dg(16'd8000, 4);

    // Duplicate bindings and missing-eof restarts.
    cfg(1, 16'd9000, 1'b1);
    cfg(3, 16'd9000, 1'b1);
    send(16'd9000, 4, -1, 1'b1, -1, 0, 16'd0, 1'b0, 1'b0);
    dg(16'd9000, 5);
    send(16'd9000, 3, -1, 1'b1, -1, 0, 16'd0, 1'b0, 1'b0);
    dg(16'd8000, 3);
    dg(16'd5000, 1);
    send(16'd5000, 6, -1, 1'b0, -1, 0, 16'd0, 1'b0, 1'b1);

    // Counter saturation.
    force dut.r_drop_cnt = 16'hFFFE;
    m_drop = 16'hFFFE;
    idle(1, 1'b0);
    release dut.r_drop_cnt;
    dg(16'd6000, 2);
    dg(16'd6000, 1);
    dg(16'd6000, 3);
    idle(1, 1'b0);

    // Asynchronous reset in the middle of a forwarded datagram.
    send(16'd5000, 4, -1, 1'b1, -1, 0, 16'd0, 1'b0, 1'b0);
    in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0; cfg_wr = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("reset_held");
    rst_n = 1'b1;
    dg(16'd5000, 3);
    dg(16'd9000, 2);
    cfg(0, 16'd5000, 1'b1);
    dg(16'd5000, 3);

    // Random traffic against a small port pool.
    for (int it = 0; it < 300; it++) begin
      logic [15:0] pool [5];
      logic [15:0] p;
      int len, err_at, cfg_at;
      bit no_eof;
      pool[0] = 16'd5000; pool[1] = 16'd6000; pool[2] = 16'd7000;
      pool[3] = 16'd8000; pool[4] = 16'd9000;
      if ($urandom_range(0, 4) == 0)
        cfg($urandom_range(0, N - 1), pool[$urandom_range(0, 4)], 1'($urandom_range(0, 1)));
      p      = pool[$urandom_range(0, 4)];
      len    = $urandom_range(1, 8);
      err_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
      no_eof = ($urandom_range(0, 11) == 0);
      cfg_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
      send(p, len, err_at, no_eof, cfg_at, $urandom_range(0, N - 1),
           pool[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2), 1'b1);
    end

    idle(2, 1'b0);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
